// File: rtl/myciel3_pkg.sv
// Shared constants, graph table and state type for the myciel3 colouring solver.
package myciel3_pkg;

  localparam int NV      = 11;
  localparam int COLOR_W = 2;
  localparam int VIDX_W  = 4;

  // Bit u of entry v is set when u < v and (u,v) is an edge of myciel3.
  localparam logic [NV-1:0] LOWER_NBR [NV] = '{
    11'h000,  // v0
    11'h001,  // v1 : 0
    11'h002,  // v2 : 1
    11'h001,  // v3 : 0
    11'h00C,  // v4 : 2,3
    11'h00A,  // v5 : 1,3
    11'h005,  // v6 : 0,2
    11'h012,  // v7 : 1,4
    11'h011,  // v8 : 0,4
    11'h00C,  // v9 : 2,3
    11'h3E0   // v10: 5,6,7,8,9
  };

  typedef enum logic [1:0] {
    IDLE,
    TRY,
    BACKTRACK,
    FINISH
  } state_t;

  // Colour of vertex idx in a packed colour vector; out-of-range indices read as 0.
  function automatic logic [COLOR_W-1:0] color_of(input logic [NV*COLOR_W-1:0] cv,
                                                  input logic [VIDX_W-1:0]     idx);
    color_of = '0;
    for (int unsigned u = 0; u < NV; u++)
      if (idx == VIDX_W'(u)) color_of = cv[COLOR_W*u +: COLOR_W];
  endfunction

endpackage

// File: rtl/myciel3_coloring_solver_if.sv
// Start/done handshake and result bus of the colouring solver.
interface myciel3_coloring_solver_if #(
  parameter int STEP_W = 16
);
  import myciel3_pkg::*;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    found;
  logic [NV*COLOR_W-1:0]   coloring;
  logic [STEP_W-1:0]       steps;

  modport master (output start, input busy, done, found, coloring, steps);
  modport slave  (input start, output busy, done, found, coloring, steps);

endinterface

// File: rtl/myciel3_conflict_check.sv
// Combinational test: does candidate colour cand clash with any committed lower neighbour of vertex?
module myciel3_conflict_check
  import myciel3_pkg::*;
(
  input  logic [VIDX_W-1:0]      vertex,
  input  logic [COLOR_W-1:0]     cand,
  input  logic [NV*COLOR_W-1:0]  colors,
  output logic                   conflict
);

  logic [NV-1:0] mask;

  // Look up the lower-neighbour mask, then compare cand against each selected colour.
  always_comb begin
    mask = '0;
    for (int unsigned v = 0; v < NV; v++)
      if (vertex == VIDX_W'(v)) mask = LOWER_NBR[v];
    conflict = 1'b0;
    for (int unsigned u = 0; u < NV; u++)
      if (mask[u] && (colors[COLOR_W*u +: COLOR_W] == cand)) conflict = 1'b1;
  end

endmodule

// File: rtl/myciel3_coloring_solver.sv
// Backtracking search for the lexicographically first proper colouring of myciel3.
module myciel3_coloring_solver
  import myciel3_pkg::*;
#(
  parameter int NUM_COLORS = 4,
  parameter int STEP_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  myciel3_coloring_solver_if.slave    bus
);

  localparam logic [COLOR_W-1:0] C_MAX  = COLOR_W'(NUM_COLORS - 1);
  localparam logic [VIDX_W-1:0]  LAST_V = VIDX_W'(NV - 1);

  state_t                 state;
  logic [VIDX_W-1:0]      v;
  logic [COLOR_W-1:0]     c;
  logic [NV*COLOR_W-1:0]  col;
  logic [NV*COLOR_W-1:0]  col_commit;
  logic [COLOR_W-1:0]     prev_col;
  logic                   conflict;
  logic                   busy_q;
  logic                   done_q;
  logic                   found_q;
  logic [STEP_W-1:0]      steps_q;

  myciel3_conflict_check u_check (
    .vertex   (v),
    .cand     (c),
    .colors   (col),
    .conflict (conflict)
  );

  // Colour vector with c written into slot v, and the committed colour of v-1.
  always_comb begin
    col_commit = col;
    for (int unsigned u = 0; u < NV; u++)
      if (v == VIDX_W'(u)) col_commit[COLOR_W*u +: COLOR_W] = c;
    prev_col = color_of(col, v - VIDX_W'(1));
  end

  // Search FSM with registered handshake outputs.
  // Slots at or above v may hold stale colours; only lower neighbours are ever compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      v       <= '0;
      c       <= '0;
      col     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      steps_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            col     <= '0;
            steps_q <= '0;
            found_q <= 1'b0;
            v       <= '0;
            c       <= '0;
            busy_q  <= 1'b1;
            state   <= TRY;
          end
        end
        TRY: begin
          if (steps_q != '1) steps_q <= steps_q + STEP_W'(1);
          if (!conflict) begin
            col <= col_commit;
            if (v == LAST_V) begin
              found_q <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state   <= FINISH;
            end else begin
              v <= v + VIDX_W'(1);
              c <= '0;
            end
          end else if (c != C_MAX) begin
            c <= c + COLOR_W'(1);
          end else begin
            state <= BACKTRACK;
          end
        end
        BACKTRACK: begin
          if (v == '0) begin
            found_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= FINISH;
          end else begin
            v <= v - VIDX_W'(1);
            if (prev_col != C_MAX) begin
              c     <= prev_col + COLOR_W'(1);
              state <= TRY;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.found    = found_q;
  assign bus.coloring = col;
  assign bus.steps    = steps_q;

endmodule

// File: tb/tb_myciel3_coloring_solver.sv
// Randomised bench for the myciel3 colouring solver: four configurations against a DFS model.
`timescale 1ns/1ps
module tb_myciel3_coloring_solver;

  localparam int ND     = 4;
  localparam int BUDGET = 40000;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int eu [20] = '{0,0,0,0,1,1,1,2,2,2,3,3,3,4,4,5,6,7,8,9};
  int ev [20] = '{1,3,6,8,2,5,7,4,6,9,4,5,9,7,8,10,10,10,10,10};

  // per-instance stimulus and observed outputs
  logic        st  [ND];
  logic        bsy [ND];
  logic        dn  [ND];
  logic        fnd [ND];
  logic [21:0] cv  [ND];
  logic [15:0] stp [ND];

  // model results and timing model state
  bit          m_found [ND];
  logic [21:0] m_col   [ND];
  int          m_steps [ND];
  int          m_lat   [ND];
  int          ph      [ND];
  int          cnt     [ND];
  bit          has     [ND];
  int          done_cnt[ND];

  myciel3_coloring_solver_if #(.STEP_W(16)) if0 ();
  myciel3_coloring_solver_if #(.STEP_W(16)) if1 ();
  myciel3_coloring_solver_if #(.STEP_W(16)) if2 ();
  myciel3_coloring_solver_if #(.STEP_W(4))  if3 ();

  myciel3_coloring_solver #(.NUM_COLORS(4), .STEP_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  myciel3_coloring_solver #(.NUM_COLORS(1), .STEP_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  myciel3_coloring_solver #(.NUM_COLORS(3), .STEP_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  myciel3_coloring_solver #(.NUM_COLORS(3), .STEP_W(4))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if3.start = st[3];

  assign bsy[0] = if0.busy;  assign dn[0] = if0.done;  assign fnd[0] = if0.found;
  assign bsy[1] = if1.busy;  assign dn[1] = if1.done;  assign fnd[1] = if1.found;
  assign bsy[2] = if2.busy;  assign dn[2] = if2.done;  assign fnd[2] = if2.found;
  assign bsy[3] = if3.busy;  assign dn[3] = if3.done;  assign fnd[3] = if3.found;
  assign cv[0] = if0.coloring;  assign stp[0] = if0.steps;
  assign cv[1] = if1.coloring;  assign stp[1] = if1.steps;
  assign cv[2] = if2.coloring;  assign stp[2] = if2.steps;
  assign cv[3] = if3.coloring;  assign stp[3] = {12'd0, if3.steps};

  // edge-validity oracle
  logic [3:0]  orc_v  = '0;
  logic [1:0]  orc_c  = '0;
  logic [21:0] orc_cv = '0;
  logic        orc_conf;
  myciel3_conflict_check orc (.vertex(orc_v), .cand(orc_c), .colors(orc_cv), .conflict(orc_conf));

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
    end
  endtask

  function automatic int k_of(input int i);
    if (i == 0) return 4;
    if (i == 1) return 1;
    return 3;
  endfunction

  function automatic bit clash(input int col[11], input int v, input int c);
    for (int e = 0; e < 20; e++)
      if (ev[e] == v && col[eu[e]] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Plain depth-first search over colour assignments in lexicographic order.
  function automatic void dfs(input int k, output bit fnd_o, output logic [21:0] pc,
                              output int tries, output int pops);
    int col[11];
    int v;
    int c;
    bit fin;
    v = 0; c = 0; fin = 1'b0; fnd_o = 1'b0; tries = 0; pops = 0; pc = '0;
    for (int i = 0; i < 11; i++) col[i] = 0;
    while (!fin) begin
      if (c >= k) begin
        pops++;
        if (v == 0) fin = 1'b1;
        else begin
          v--;
          c = col[v] + 1;
        end
      end else begin
        tries++;
        if (clash(col, v, c)) c++;
        else begin
          col[v] = c;
          if (v == 10) begin
            fnd_o = 1'b1;
            fin = 1'b1;
          end else begin
            v++;
            c = 0;
          end
        end
      end
    end
    for (int i = 0; i < 11; i++) pc[2*i +: 2] = 2'(col[i]);
  endfunction

  // Handshake timing model: accept in idle, run for the search latency, one finish cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) begin
        ph[i]  <= P_IDLE;
        cnt[i] <= 0;
        has[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ND; i++) begin
        if (ph[i] == P_IDLE) begin
          if (st[i]) begin
            ph[i]  <= P_RUN;
            cnt[i] <= m_lat[i];
          end
        end else if (ph[i] == P_RUN) begin
          if (cnt[i] <= 1) begin
            ph[i]  <= P_FIN;
            has[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 1;
          end
        end else begin
          ph[i] <= P_IDLE;
        end
      end
    end
  end

  // Compare every instance against the model just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("busy", i, 32'(bsy[i]), 32'(ph[i] == P_RUN));
      chk("done", i, 32'(dn[i]), 32'(ph[i] == P_FIN));
      if (dn[i]) done_cnt[i]++;
      if (ph[i] != P_RUN) begin
        chk("found", i, 32'(fnd[i]), has[i] ? 32'(m_found[i]) : 32'd0);
        chk("steps", i, 32'(stp[i]), has[i] ? 32'(m_steps[i]) : 32'd0);
        if (!has[i] || m_found[i])
          chk("coloring", i, 32'(cv[i]), has[i] ? 32'(m_col[i]) : 32'd0);
      end
    end
  end

  task automatic wait_done(input int i, input int base);
    int n;
    n = 0;
    while (done_cnt[i] == base && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", i, 32'(done_cnt[i] > base), 32'd1);
  endtask

  task automatic check_edges(input int i, input logic [21:0] cvv);
    for (int e = 0; e < 20; e++)
      chk("edge_differs", i*100 + e, 32'(cvv[2*eu[e] +: 2] != cvv[2*ev[e] +: 2]), 32'd1);
    for (int v = 0; v < 11; v++) begin
      orc_v  = 4'(v);
      orc_c  = cvv[2*v +: 2];
      orc_cv = cvv;
      #1;
      chk("oracle_conflict", i*100 + v, 32'(orc_conf), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base [ND];
    int n;
    bit f;
    logic [21:0] pc;
    int t;
    int p;
    int maxv;

    for (int i = 0; i < ND; i++) begin
      st[i] = 1'b0;
      dfs(k_of(i), f, pc, t, p);
      maxv = (i == 3) ? 15 : 65535;
      m_found[i] = f;
      m_col[i]   = pc;
      m_steps[i] = (t > maxv) ? maxv : t;
      m_lat[i]   = t + p;
    end

    // pin the model with hand-derived values
    chk("model_found4", 0, 32'(m_found[0]), 32'd1);
    chk("model_col4", 0, 32'(m_col[0]), 32'h391244);
    chk("model_steps4", 0, 32'(m_steps[0]), 32'd22);
    chk("model_found1", 1, 32'(m_found[1]), 32'd0);
    chk("model_steps1", 1, 32'(m_steps[1]), 32'd2);
    chk("model_lat1", 1, 32'(m_lat[1]), 32'd4);
    chk("model_found3", 2, 32'(m_found[2]), 32'd0);
    chk("model_sat3", 3, 32'(m_steps[3]), 32'hF);

    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // one search on every configuration at once
    for (int i = 0; i < ND; i++) begin
      base[i] = done_cnt[i];
      st[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < ND; i++) st[i] = 1'b0;
    for (int i = 0; i < ND; i++) wait_done(i, base[i]);
    chk("lit_col4", 0, 32'(cv[0]), 32'h391244);
    chk("lit_steps4", 0, 32'(stp[0]), 32'd22);
    chk("lit_found1", 1, 32'(fnd[1]), 32'd0);
    chk("lit_steps1", 1, 32'(stp[1]), 32'd2);
    chk("lit_found3", 2, 32'(fnd[2]), 32'd0);
    chk("lit_steps3_nonzero", 2, 32'(stp[2] != 16'd0), 32'd1);
    chk("lit_busy3_low", 2, 32'(bsy[2]), 32'd0);
    chk("lit_sat", 3, 32'(stp[3]), 32'hF);
    check_edges(0, cv[0]);

    // start held high through the search and the finish cycle
    base[0] = done_cnt[0];
    st[0] = 1'b1;
    @(negedge clk);
    n = 0;
    while (bsy[0] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("held_start_ends", 0, 32'(bsy[0]), 32'd0);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_start_single", 0, 32'(done_cnt[0] - base[0]), 32'd1);
    chk("held_start_col", 0, 32'(cv[0]), 32'h391244);
    chk("held_start_steps", 0, 32'(stp[0]), 32'd22);

    // reset in the middle of a search, then a clean restart
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    base[0] = done_cnt[0];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 0, 32'(bsy[0]), 32'd0);
    chk("reset_col", 0, 32'(cv[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_no_done", 0, 32'(done_cnt[0] - base[0]), 32'd0);
    base[0] = done_cnt[0];
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, base[0]);
    chk("restart_col", 0, 32'(cv[0]), 32'h391244);
    check_edges(0, cv[0]);

    // random start traffic with occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < ND; i++) st[i] = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      @(negedge clk);
    end
    for (int i = 0; i < ND; i++) st[i] = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while ((bsy[0] || bsy[1] || bsy[2] || bsy[3] || ph[0] != P_IDLE || ph[1] != P_IDLE ||
            ph[2] != P_IDLE || ph[3] != P_IDLE) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("quiesce", 0, 32'(n < BUDGET), 32'd1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/myciel3_coloring_solver.md
Name: myciel3_coloring_solver

Overview:
- Sequential backtracking search engine that produces a proper vertex colouring of the fixed 11-vertex Mycielski graph myciel3 (20 edges).
- It is the producer counterpart of the combinational colouring checker. The coloring bus uses the same packing, so the output drops straight into the checker's inputs.
- It sits behind a start/done handshake. It reports the first valid colouring in deterministic lexicographic order, or reports exhaustion.

Parameters:
- NUM_COLORS, 4, number of usable colours (1..4); colours 0..NUM_COLORS-1.
- STEP_W, 16, width of the saturating try-step counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the search ends.
- found  output  1  valid with done and held after it; 1 = colouring found, 0 = exhausted.
- coloring  output  22  vertex v colour at bits [2v+1:2v]; held after done.
- steps  output  STEP_W  count of TRY evaluations in the last search; saturates at all-ones.

Behaviour:
- Edges, as (u,v): 0-1, 0-3, 0-6, 0-8, 1-2, 1-5, 1-7, 2-4, 2-6, 2-9, 3-4, 3-5, 3-9, 4-7, 4-8, 5-10, 6-10, 7-10, 8-10, 9-10.
- Lower-neighbour sets:
  - v1:{0}, v2:{1}, v3:{0}, v4:{2,3}, v5:{1,3}
  - v6:{0,2}, v7:{1,4}, v8:{0,4}, v9:{2,3}, v10:{5,6,7,8,9}
- Reset values:
  - busy=0, done=0, found=0, coloring=0, steps=0; state=IDLE.
  - Internal vertex index and candidate colour are cleared.
- FSM states: IDLE, TRY, BACKTRACK, FINISH.
- IDLE:
  - start=1 → clear colour regs, steps and found.
  - Set vertex v=0, candidate c=0, go to TRY; busy rises next cycle.
- TRY (one cycle per evaluation; steps += 1, saturating):
  - A conflict exists when c equals the committed colour of any lower neighbour of v.
  - No conflict: commit col[v]=c.
    - If v=10: found←1, go to FINISH.
    - Otherwise: v←v+1, c←0.
  - Conflict and c<NUM_COLORS-1: c←c+1, stay in TRY.
  - Conflict and c=NUM_COLORS-1: go to BACKTRACK.
- BACKTRACK (one cycle per step):
  - If v=0: found←0, go to FINISH (space exhausted).
  - Otherwise v←v-1.
    - If col[v-1]<NUM_COLORS-1: c←col[v-1]+1, go to TRY.
    - Otherwise remain in BACKTRACK.
- FINISH:
  - done=1 for exactly one cycle, busy←0.
  - coloring shows the committed colour regs.
  - Go to IDLE.
- coloring:
  - Driven from the colour registers at all times.
  - During busy its value is don't-care to consumers.
  - On found=0 its content is unspecified but stable.
- start while busy=1 is ignored; no queuing.
- start in the FINISH cycle is ignored.
- Asynchronous reset mid-search aborts immediately to reset values; no done pulse.
- Colour width is fixed at 2 bits. Candidate comparisons are 2-bit equality; c never exceeds NUM_COLORS-1.
- A found colouring always has differing colours on all 20 edges.

Decomposition:
- Package myciel3_pkg holds:
  - NV=11 and COLOR_W=2.
  - Lower-neighbour mask table, a constant 11×11-bit array.
  - State enum.
- Sub-module myciel3_conflict_check: combinational.
  - Inputs: vertex index, candidate colour, 22-bit colour vector.
  - Output: conflict flag.
  - Reused by the bench as an edge-validity oracle.

Test Plan:
- NUM_COLORS=4: reset, pulse start → done after 22 TRY cycles; found=1, coloring=22'h391244 (v0..v10 = 0,1,0,1,2,0,1,0,1,2,3), steps=22.
- NUM_COLORS=1: start → found=0, steps=2 (v0 committed, v1 conflicts, then backtrack exhausts at v0).
- NUM_COLORS=3: start → found=0 (chromatic number is 4); steps nonzero; done pulse exactly one cycle; busy low afterwards.
- Start re-pulsed every cycle while busy (NUM_COLORS=4) → single search only; result still 22'h391244, steps=22.
- Assert rst_n low mid-search (cycle 10), then release and restart → all outputs at reset values during reset, no done pulse; the restarted search gives 22'h391244.
- Every found=1 result fed through the 20-edge check → all edges have differing colours; steps saturation is forced with STEP_W=4 and NUM_COLORS=3 → steps=4'hF.
